// File: rtl/i2c_reg_master.sv
// i2c_reg_master: one-shot I2C master that writes or reads one 8-bit register over open-drain SCL/SDA.
// Done comes 116*CLK_DIV (write) / 156*CLK_DIV (read) cycles after busy rises; define I2C_CLK_STRETCH_EN for SCL stretching.
module i2c_reg_master #(
  parameter int CLK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startReq,
  input  logic       rdNotWr,
  input  logic [6:0] devAddr,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  output logic [7:0] rdData,
  output logic       sclOe,
  output logic       sdaOe,
  input  logic       sclIn,
  input  logic       sdaIn
);
  typedef enum logic [3:0] {
    IDLE, START, ADDRW, REG, WDATA, RSTART, ADDRR, RDATA, MNACK, STOP
  } state_t;

  state_t      state;
  logic [15:0] divCnt;
  logic [1:0]  q;
  logic [3:0]  bitIdx;
  logic [7:0]  txShift;
  logic [7:0]  rxShift;
  logic        cmdRd;
  logic [6:0]  cmdDev;
  logic [7:0]  cmdReg;
  logic [7:0]  cmdWr;
  logic        ackSample;
  logic        hold;
  logic        tick;
  logic        lastBit;
  logic        sclNext;
  logic        sdaNext;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we have released it freezes the quarter.
  assign hold = q[1] && !sclOe && !sclIn;
`else
  assign hold = sclIn & 1'b0;
`endif

  assign tick = (state != IDLE) && !hold && (divCnt == 16'(CLK_DIV - 1));

  always_comb begin
    lastBit = 1'b1;
    case (state)
      ADDRW, REG, WDATA, ADDRR: lastBit = (bitIdx == 4'd8);
      RDATA:                    lastBit = (bitIdx == 4'd7);
      default:                  lastBit = 1'b1;
    endcase
  end

  // Line levels for the current quarter; registered into sclOe/sdaOe below.
  always_comb begin
    sclNext = 1'b0;
    sdaNext = 1'b0;
    case (state)
      START, RSTART: begin
        sdaNext = q[1];
        sclNext = &q;
      end
      STOP: begin
        sclNext = (q == 2'd0);
        sdaNext = (q != 2'd3);
      end
      ADDRW, REG, WDATA, ADDRR: begin
        sclNext = !q[1];
        sdaNext = (bitIdx < 4'd8) && !txShift[7];
      end
      RDATA, MNACK: sclNext = !q[1];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      divCnt    <= '0;
      q         <= '0;
      bitIdx    <= '0;
      txShift   <= '0;
      rxShift   <= '0;
      cmdRd     <= 1'b0;
      cmdDev    <= '0;
      cmdReg    <= '0;
      cmdWr     <= '0;
      ackSample <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ackErr    <= 1'b0;
      rdData    <= '0;
      sclOe     <= 1'b0;
      sdaOe     <= 1'b0;
    end else begin
      sclOe <= sclNext;
      sdaOe <= sdaNext;
      if (done) begin
        done <= 1'b0;
        busy <= 1'b0;
      end else if (!busy) begin
        if (startReq) begin
          busy   <= 1'b1;
          state  <= START;
          cmdRd  <= rdNotWr;
          cmdDev <= devAddr;
          cmdReg <= regAddr;
          cmdWr  <= wrData;
          ackErr <= 1'b0;
          divCnt <= '0;
          q      <= '0;
          bitIdx <= '0;
        end
      end else begin
        if (hold || tick) divCnt <= '0;
        else              divCnt <= divCnt + 16'd1;
        if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd2) begin
            ackSample <= sdaIn;
            if (state == RDATA) rxShift <= {rxShift[6:0], sdaIn};
          end
          if (q == 2'd3) begin
            if (!lastBit) begin
              bitIdx  <= bitIdx + 4'd1;
              txShift <= {txShift[6:0], 1'b0};
            end else begin
              bitIdx <= '0;
              case (state)
                START: begin
                  state   <= ADDRW;
                  txShift <= {cmdDev, 1'b0};
                end
                ADDRW: begin
                  if (ackSample) begin
                    ackErr <= 1'b1;
                    state  <= STOP;
                  end else begin
                    state   <= REG;
                    txShift <= cmdReg;
                  end
                end
                REG: begin
                  if (ackSample) begin
                    ackErr <= 1'b1;
                    state  <= STOP;
                  end else if (cmdRd) begin
                    state <= RSTART;
                  end else begin
                    state   <= WDATA;
                    txShift <= cmdWr;
                  end
                end
                WDATA: begin
                  ackErr <= ackSample;
                  state  <= STOP;
                end
                RSTART: begin
                  state   <= ADDRR;
                  txShift <= {cmdDev, 1'b1};
                end
                ADDRR: begin
                  if (ackSample) begin
                    ackErr <= 1'b1;
                    state  <= STOP;
                  end else begin
                    state <= RDATA;
                  end
                end
                RDATA: state <= MNACK;
                MNACK: state <= STOP;
                STOP: begin
                  state <= IDLE;
                  done  <= 1'b1;
                  if (cmdRd && !ackErr) rdData <= rxShift;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed bench for i2c_reg_master with a behavioural register-bank slave at address 0x3C.
module tb_i2c_reg_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       startReq, rdNotWr;
  logic [6:0] devAddr;
  logic [7:0] regAddr, wrData;
  logic       busy, done, ackErr;
  logic [7:0] rdData;
  logic       sclOe, sdaOe;
  logic       sclIn, sdaIn;

  logic slvScl = 1'b0;
  logic slvSda = 1'b0;
  assign sclIn = !(sclOe || slvScl);
  assign sdaIn = !(sdaOe || slvSda);

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .startReq(startReq), .rdNotWr(rdNotWr),
    .devAddr(devAddr), .regAddr(regAddr), .wrData(wrData),
    .busy(busy), .done(done), .ackErr(ackErr), .rdData(rdData),
    .sclOe(sclOe), .sdaOe(sdaOe), .sclIn(sclIn), .sdaIn(sdaIn)
  );

  int vecs = 0;
  int errs = 0;
  int doneCnt = 0;

  // Bus log tokens: 9'h100 = START, 9'h101 = STOP, {1'b0, byte} = data byte.
  logic [8:0] busLog[$];
  logic [8:0] expQ[$];

  // Slave model state
  logic [7:0] regs [256];
  logic       prevScl = 1'b1, prevSclOe = 1'b0, prevSdaOe = 1'b0;
  int         bitCnt = 0, byteIdx = 0, holdLeft = 0;
  logic [7:0] shReg = 8'h00, txByte = 8'h00, regPtr = 8'h00;
  logic       active = 1'b0, rdMode = 1'b0, txMode = 1'b0, stretchArm = 1'b0;

  always @(negedge clk) begin
    if (done) doneCnt++;
    if (holdLeft > 0) begin
      holdLeft--;
      if (holdLeft == 0) slvScl = 1'b0;
    end
    if (!prevSclOe && !sclOe && !prevSdaOe && sdaOe) begin
      busLog.push_back(9'h100);
      bitCnt = 0; byteIdx = 0; txMode = 1'b0; slvSda = 1'b0; active = 1'b1;
    end else if (!prevSclOe && !sclOe && prevSdaOe && !sdaOe) begin
      busLog.push_back(9'h101);
      active = 1'b0; txMode = 1'b0; slvSda = 1'b0;
    end else if (sclIn && !prevScl) begin
      if (bitCnt < 8 && !txMode) shReg = {shReg[6:0], sdaIn};
      bitCnt++;
    end else if (!sclIn && prevScl) begin
      if (bitCnt == 8) begin
        if (txMode) begin
          slvSda = 1'b0;
          busLog.push_back({1'b0, txByte});
        end else begin
          busLog.push_back({1'b0, shReg});
          if (byteIdx == 0) begin
            active = (shReg[7:1] == 7'h3C);
            rdMode = shReg[0];
          end else if (active && byteIdx == 1) begin
            regPtr = shReg;
          end else if (active && byteIdx == 2) begin
            regs[regPtr] = shReg;
          end
          slvSda = active;
        end
      end else if (bitCnt == 9) begin
        bitCnt = 0;
        byteIdx++;
        slvSda = 1'b0;
        if (txMode) txMode = 1'b0;
        else if (active && rdMode && byteIdx == 1) begin
          txMode = 1'b1;
          txByte = regs[regPtr];
          slvSda = !txByte[7];
        end
        if (stretchArm && active && !rdMode && byteIdx == 2) begin
          slvScl = 1'b1;
          holdLeft = 50;
        end
      end else if (txMode && bitCnt > 0 && bitCnt < 8) begin
        slvSda = !txByte[7 - bitCnt];
      end
    end
    prevScl   = sclIn;
    prevSclOe = sclOe;
    prevSdaOe = sdaOe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int exp, input int tol);
    vecs++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic checkLog(input string tag);
    check({tag, "_len"}, busLog.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < busLog.size()) check($sformatf("%s[%0d]", tag, i), busLog[i], expQ[i]);
    end
  endtask

  // Issue one command; lat = cycles from first busy cycle to the done cycle.
  task automatic runCmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int pokeAt, output int lat);
    @(negedge clk);
    rdNotWr = rd; devAddr = dev; regAddr = ra; wrData = wd; startReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0;
    check("busyAtAccept", busy, 1);
    check("ackErrClrAtAccept", ackErr, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 5000) begin
      if (lat == pokeAt) begin
        startReq = 1'b1;
        regAddr  = 8'h07;
      end else if (lat == pokeAt + 1) begin
        startReq = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    startReq = 1'b0;
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[2] = 8'h5A;
    rst = 1'b1; startReq = 1'b0; rdNotWr = 1'b0;
    devAddr = 7'h00; regAddr = 8'h00; wrData = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstAckErr", ackErr, 0);
    check("rstRdData", rdData, 8'h00);
    check("rstSclOe", sclOe, 0);
    check("rstSdaOe", sdaOe, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Register write
    busLog.delete(); doneCnt = 0;
    runCmd(1'b0, 7'h3C, 8'h05, 8'hA7, -1, lat);
    checkRange("wrLatency", lat, 116 * CLK_DIV, 2);
    check("wrAckErr", ackErr, 0);
    @(posedge clk); #1;
    check("wrBusyDrop", busy, 0);
    check("wrDonePulse", done, 0);
    repeat (4) @(posedge clk);
    check("wrReg5", regs[5], 8'hA7);
    check("wrDoneCnt", doneCnt, 1);
    expQ = {9'h100, 9'h078, 9'h005, 9'h0A7, 9'h101};
    checkLog("wrBus");

    // Register read
    busLog.delete();
    runCmd(1'b1, 7'h3C, 8'h02, 8'h00, -1, lat);
    checkRange("rdLatency", lat, 156 * CLK_DIV, 2);
    check("rdData", rdData, 8'h5A);
    check("rdAckErr", ackErr, 0);
    repeat (4) @(posedge clk);
    expQ = {9'h100, 9'h078, 9'h002, 9'h100, 9'h079, 9'h05A, 9'h101};
    checkLog("rdBus");

    // Wrong device address: NACK on the first byte
    busLog.delete();
    runCmd(1'b1, 7'h10, 8'h05, 8'h11, -1, lat);
    checkRange("nackLatency", lat, 44 * CLK_DIV, 2);
    check("nackAckErr", ackErr, 1);
    check("nackRdData", rdData, 8'h5A);
    repeat (4) @(posedge clk);
    check("nackReg5", regs[5], 8'hA7);
    expQ = {9'h100, 9'h020, 9'h101};
    checkLog("nackBus");

    // startReq while busy is ignored
    busLog.delete(); doneCnt = 0;
    runCmd(1'b0, 7'h3C, 8'h05, 8'hC3, 10, lat);
    checkRange("ignLatency", lat, 116 * CLK_DIV, 2);
    check("ignAckErr", ackErr, 0);
    repeat (20) @(posedge clk);
    #1;
    check("ignBusyIdle", busy, 0);
    check("ignDoneCnt", doneCnt, 1);
    check("ignReg5", regs[5], 8'hC3);
    check("ignReg7", regs[7], 8'h00);

    // Asynchronous reset in the middle of the REG byte
    @(negedge clk);
    rdNotWr = 1'b0; devAddr = 7'h3C; regAddr = 8'h06; wrData = 8'h99; startReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0;
    repeat (226) @(posedge clk);
    #1;
    check("midSclLow", sclOe, 1);
    check("midSdaLow", sdaOe, 1);
    rst = 1'b1;
    #1;
    check("arstSclOe", sclOe, 0);
    check("arstSdaOe", sdaOe, 0);
    check("arstBusy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    check("arstReg6", regs[6], 8'h00);

    busLog.delete();
    runCmd(1'b0, 7'h3C, 8'h03, 8'h3E, -1, lat);
    checkRange("postRstLatency", lat, 116 * CLK_DIV, 2);
    check("postRstAckErr", ackErr, 0);
    repeat (4) @(posedge clk);
    check("postRstReg3", regs[3], 8'h3E);
    expQ = {9'h100, 9'h078, 9'h003, 9'h03E, 9'h101};
    checkLog("postRstBus");

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 50 cycles after the REG acknowledge
    busLog.delete(); stretchArm = 1'b1;
    runCmd(1'b0, 7'h3C, 8'h04, 8'h5C, -1, lat);
    stretchArm = 1'b0;
    checkRange("stretchLatency", lat, 116 * CLK_DIV + 46, 10);
    check("stretchAckErr", ackErr, 0);
    repeat (4) @(posedge clk);
    check("stretchReg4", regs[4], 8'h5C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- Single-transaction I2C master that writes or reads one 8-bit register in an I2C slave register bank (8-bit register address, 8-bit data).
- Sits on the host/test side, opposite our I2C slave register bank.
- Host issues one command; the block drives open-drain SCL/SDA and reports completion, read data and ACK errors.

Parameters:
- CLK_DIV, 64, clk cycles per SCL quarter-period; SCL freq = clk / (4*CLK_DIV); legal range 2..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- startReq  in  1  command strobe; sampled only when busy=0.
- rdNotWr  in  1  command type: 1 = register read, 0 = register write.
- devAddr  in  7  slave 7-bit device address.
- regAddr  in  8  register address.
- wrData  in  8  write data.
- busy  out  1  high from the cycle after an accepted startReq until the done cycle, inclusive.
- done  out  1  one-cycle pulse at the end of a transaction.
- ackErr  out  1  status of the last transaction: slave NACKed any byte; valid from done.
- rdData  out  8  last successfully read byte.
- sclOe  out  1  1 = pull SCL low (open-drain).
- sdaOe  out  1  1 = pull SDA low.
- sclIn  in  1  SCL line level (used only with the optional feature).
- sdaIn  in  1  SDA line level.

Behaviour:
- Reset (async) values: busy=0, done=0, ackErr=0, rdData=0x00, sclOe=0, sdaOe=0, FSM=IDLE, quarter counter=0. Lines are released immediately on rst, including mid-transaction; no STOP is generated.
- Quarter tick: a counter counts 0..CLK_DIV-1 and pulses tick at wrap. All FSM phase changes occur on tick. Each phase is 4 quarters, q0..q3.
- Bit phase:
  - q0: SCL low; drive SDA to the bit value.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL released.
  - sdaIn is sampled at the q2->q3 tick.
- START / repeated START: q0 and q1 release SDA and SCL; q2 SDA low; q3 SCL low.
- STOP: q0 SCL low, SDA low; q1 SCL released; q2 SCL released; q3 SDA released.
- Bytes are sent MSB first. Each byte is followed by a 9th ACK bit: the master releases SDA and samples; sdaIn=0 means ACK.
- FSM states: IDLE, START, ADDRW, REG, WDATA, RSTART, ADDRR, RDATA, MNACK, STOP.
- Write sequence: START, {devAddr,0}, REG(regAddr), WDATA(wrData), STOP.
- Read sequence: START, {devAddr,0}, REG(regAddr), RSTART, {devAddr,1}, RDATA (8 bits sampled, SDA released), MNACK (master drives SDA high on the 9th bit), STOP.
- Latency from an accepted startReq (busy=1 next cycle) to done: write = 116*CLK_DIV cycles, read = 156*CLK_DIV cycles, each +-2 cycles.
- NACK on any slave ACK bit: ackErr=1, skip remaining bytes, go to STOP, then done. rdData is unchanged.
- On a successful read, rdData updates in the same cycle as done. ackErr clears at the accept of each new command.
- startReq while busy=1 is ignored (not queued). startReq in the done cycle is ignored; it is accepted from the following cycle.
- Command inputs are latched at accept; changes during busy have no effect.
- Arbitration loss is not detected: single-master bus.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: in q2/q3 of any phase, while sclOe=0 and sclIn=0, the quarter counter holds. The phase proceeds a full quarter after sclIn returns high, so latency extends by the stretch time.
- Undefined: sclIn is ignored; timing is exactly as above.

Test Plan:
- Write, CLK_DIV=4, devAddr=0x3C, regAddr=0x05, wrData=0xA7, slave model ACKs all -> slave reg5=0xA7; done after 464+-2 cycles; ackErr=0; bus shows START, 0x78, 0x05, 0xA7, STOP.
- Read, regAddr=0x02, slave reg2=0x5A -> bus shows START, 0x78, 0x02, Sr, 0x79; rdData=0x5A at done; master NACK on the last bit; done after 624+-2 cycles.
- Wrong devAddr=0x10 (slave at 0x3C) -> NACK on the first byte; ackErr=1; STOP; done after (4+36+4)*CLK_DIV+-2 cycles; rdData unchanged.
- startReq pulsed 10 cycles after accept with different regAddr -> ignored; the original transaction completes unchanged; exactly one done pulse.
- rst asserted mid-REG byte -> same cycle sclOe=0, sdaOe=0, busy=0; a new write after reset release completes correctly.
- With I2C_CLK_STRETCH_EN, slave holds SCL low 50 cycles after the REG ACK -> counter frozen; data intact; done delayed by ~50 cycles.
